// File: rtl/caravel_io_pkg.sv
// Shared constants and state encoding for the Caravel-style I/O sequencer.
package caravel_io_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } seq_state_t;

endpackage

// File: rtl/caravel_io_sequencer_spi.sv
// SPI mode-0 read master: divides clock down to flash_clk, shifts a fixed
// 32-bit header out on io0 (then zeros) and assembles io1 into bytes.
// byte_valid pulses for one clock after the 8th rising flash_clk edge of
// every byte, header bytes included; the caller decides which ones matter.
module spi_read_master #(
    parameter int          CLKDIV = 2,
    parameter logic [31:0] HEADER = 32'h0300_0000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic       flash_csb,
    output logic       flash_clk,
    output logic       flash_io0,
    input  logic       flash_io1,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int          DW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLKDIV - 1);

    logic          active;
    logic [DW-1:0] div_cnt;
    logic [31:0]   tx_sr;
    logic [6:0]    rx_sr;
    logic [2:0]    bit_left;

    // Divider, shift registers and bit counter; stop parks the bus idle.
    always_ff @(posedge clock) begin
        if (rst || stop) begin
            active     <= 1'b0;
            flash_csb  <= 1'b1;
            flash_clk  <= 1'b0;
            flash_io0  <= 1'b0;
            div_cnt    <= DIV_LOAD;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_left   <= 3'd7;
            byte_valid <= 1'b0;
            byte_data  <= '0;
        end else begin
            byte_valid <= 1'b0;
            if (start) begin
                active    <= 1'b1;
                flash_csb <= 1'b0;
                flash_clk <= 1'b0;
                flash_io0 <= HEADER[31];
                tx_sr     <= {HEADER[30:0], 1'b0};
                div_cnt   <= DIV_LOAD;
                bit_left  <= 3'd7;
            end else if (active) begin
                if (div_cnt == '0) begin
                    div_cnt   <= DIV_LOAD;
                    flash_clk <= ~flash_clk;
                    if (!flash_clk) begin
                        // rising edge: sample MISO
                        rx_sr <= {rx_sr[5:0], flash_io1};
                        if (bit_left == 3'd0) begin
                            bit_left   <= 3'd7;
                            byte_valid <= 1'b1;
                            byte_data  <= {rx_sr, flash_io1};
                        end else begin
                            bit_left <= bit_left - 3'd1;
                        end
                    end else begin
                        // falling edge: present next MOSI bit
                        flash_io0 <= tx_sr[31];
                        tx_sr     <= {tx_sr[30:0], 1'b0};
                    end
                end else begin
                    div_cnt <= div_cnt - DW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/caravel_io_sequencer.sv
// Harness top: fetches NUM_BYTES from SPI flash after reset and plays them
// out on mprj_io[7:0]; gpio flags completion.
//
// state | meaning
// IDLE  | reset just released; kick off the read (or skip when NUM_BYTES==0)
// CMD   | shifting out the 0x03 read command
// ADDR  | shifting out the 24-bit start address (three bytes)
// DATA  | streaming data bytes to the pad register
// DONE  | all bytes played; flash idle, pads hold last byte, gpio=1
module caravel_io_sequencer
    import caravel_io_pkg::*;
#(
    parameter int          CLKDIV     = 2,
    parameter int          NUM_BYTES  = 12,
    parameter logic [23:0] START_ADDR = 24'h0
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        vccd,
    input  logic        vccd1,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1,
    inout  wire  [37:0] mprj_io,
    output logic        gpio
);

    localparam int             BCW        = (NUM_BYTES > 0) ? $clog2(NUM_BYTES + 1) : 1;
    localparam logic [BCW-1:0] BYTES_LOAD = BCW'(NUM_BYTES);

    logic           rst;
    seq_state_t     state, state_nxt;
    logic           start, stop;
    logic           byte_valid;
    logic [7:0]     byte_data;
    logic [7:0]     pad_q;
    logic [BCW-1:0] bytes_left;
    logic [1:0]     addr_left;

    assign rst  = !resetb || !vccd || !vccd1;
    assign stop = (state == DONE);
    assign gpio = (state == DONE);

    assign mprj_io[7:0]  = pad_q;
    assign mprj_io[37:8] = {30{1'bz}};

    spi_read_master #(
        .CLKDIV (CLKDIV),
        .HEADER ({CMD_READ, START_ADDR})
    ) u_spi (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .flash_csb  (flash_csb),
        .flash_clk  (flash_clk),
        .flash_io0  (flash_io0),
        .flash_io1  (flash_io1),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start is a one-clock pulse out of IDLE.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (NUM_BYTES == 0) begin
                    state_nxt = DONE;
                end else begin
                    start     = 1'b1;
                    state_nxt = CMD;
                end
            end
            CMD:  if (byte_valid) state_nxt = ADDR;
            ADDR: if (byte_valid && addr_left == 2'd0) state_nxt = DATA;
            DATA: if (byte_valid && bytes_left == BCW'(1)) state_nxt = DONE;
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address/byte down-counters and the pad output register.
    always_ff @(posedge clock) begin
        if (rst) begin
            pad_q      <= 8'h00;
            bytes_left <= BYTES_LOAD;
            addr_left  <= 2'd2;
        end else begin
            if (state == ADDR && byte_valid) addr_left <= addr_left - 2'd1;
            if (state == DATA && byte_valid) begin
                pad_q      <= byte_data;
                bytes_left <= bytes_left - BCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_caravel_io_sequencer.sv
// Bench for caravel_io_sequencer: SPI flash model, byte scoreboard, reset and
// power-good sequencing, plus a NUM_BYTES=0 instance.
module tb_caravel_io_sequencer;

    localparam int CLKDIV    = 2;
    localparam int NUM_BYTES = 12;
    localparam int BYTE_CLKS = 16 * CLKDIV;
    localparam int FIRST_LAT = 2 + CLKDIV + 39 * 2 * CLKDIV;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetb = 1'b0, resetb0 = 1'b0, vccd = 1'b1, vccd1 = 1'b1;
    logic flash_csb, flash_clk, flash_io0, gpio;
    logic flash_io1 = 1'b0;
    wire [37:0] mprj_io;
    logic flash_csb0, flash_clk0, flash_io00, gpio0;
    wire [37:0] mprj_io0;

    logic [7:0] image [NUM_BYTES];
    logic [7:0] exp_q [$];
    int         bitpos = 0;
    logic [31:0] hdr_cap = '0;
    int  n_vec = 0, n_err = 0;
    bit  hiz_bad = 0, csb0_bad = 0, io0_bad = 0;

    caravel_io_sequencer #(.CLKDIV(CLKDIV), .NUM_BYTES(NUM_BYTES), .START_ADDR(24'h0)) dut (
        .clock(clock), .resetb(resetb), .vccd(vccd), .vccd1(vccd1),
        .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0),
        .flash_io1(flash_io1), .mprj_io(mprj_io), .gpio(gpio));

    caravel_io_sequencer #(.CLKDIV(CLKDIV), .NUM_BYTES(0), .START_ADDR(24'h0)) dut0 (
        .clock(clock), .resetb(resetb0), .vccd(1'b1), .vccd1(1'b1),
        .flash_csb(flash_csb0), .flash_clk(flash_clk0), .flash_io0(flash_io00),
        .flash_io1(1'b0), .mprj_io(mprj_io0), .gpio(gpio0));

    function automatic logic flash_bit(input int p);
        logic [7:0] b;
        int d;
        if (p < 32) return 1'b0;
        d = (p - 32) / 8;
        if (d >= NUM_BYTES) return 1'b0;
        b = image[d];
        return b[7 - ((p - 32) % 8)];
    endfunction

    // Flash model: restart on chip select, capture header on rising edges.
    always @(posedge flash_clk or negedge flash_csb) begin
        if (!flash_clk) begin
            bitpos  = 0;
            hdr_cap = '0;
        end else if (!flash_csb) begin
            if (bitpos < 32) hdr_cap = {hdr_cap[30:0], flash_io0};
            else if (flash_io0 !== 1'b0) io0_bad = 1;
            bitpos++;
        end
    end

    // Flash model: drive next data bit on falling flash_clk.
    always @(negedge flash_clk or negedge flash_csb) begin
        flash_io1 = flash_bit(bitpos);
    end

    // Continuous probes of the unused pads and the NUM_BYTES=0 chip select.
    always @(negedge clock) begin
        if (mprj_io[37:8] !== {30{1'bz}} || mprj_io0[37:8] !== {30{1'bz}}) hiz_bad = 1;
        if (flash_csb0 !== 1'b1) csb0_bad = 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge where reset/power-good was just released.
    task automatic run_sequence(input string tag, input int nb);
        logic [7:0] last, e;
        int waited;
        exp_q.delete();
        for (int i = 0; i < NUM_BYTES; i++) exp_q.push_back(image[i]);
        last = 8'h00;
        @(negedge clock);
        check({tag, " csb_start"}, {31'b0, flash_csb}, 32'd0);
        waited = 1;
        for (int b = 0; b < nb; b++) begin
            while (mprj_io[7:0] === last && waited < FIRST_LAT + BYTE_CLKS) begin
                @(negedge clock);
                waited++;
            end
            e = exp_q.pop_front();
            check({tag, " byte"}, {24'b0, mprj_io[7:0]}, {24'b0, e});
            check({tag, " spacing"}, waited, (b == 0) ? FIRST_LAT : BYTE_CLKS);
            if (b == 0) check({tag, " header"}, hdr_cap, 32'h0300_0000);
            last   = mprj_io[7:0];
            waited = 0;
        end
        if (nb == NUM_BYTES) begin
            @(negedge clock);
            check({tag, " done_gpio"}, {31'b0, gpio}, 32'd1);
            check({tag, " done_csb"}, {31'b0, flash_csb}, 32'd1);
            check({tag, " done_clk"}, {31'b0, flash_clk}, 32'd0);
            repeat (20) @(negedge clock);
            check({tag, " hold_pads"}, {24'b0, mprj_io[7:0]}, {24'b0, last});
            check({tag, " hold_csb"}, {31'b0, flash_csb}, 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 10; i++) image[i] = 8'(i + 1);
        image[10] = 8'hFF;
        image[11] = 8'h00;

        repeat (3) @(negedge clock);
        check("rst_csb", {31'b0, flash_csb}, 32'd1);
        check("rst_clk", {31'b0, flash_clk}, 32'd0);
        check("rst_io0", {31'b0, flash_io0}, 32'd0);
        check("rst_pads", {24'b0, mprj_io[7:0]}, 32'd0);
        check("rst_gpio", {31'b0, gpio}, 32'd0);
        check("nb0_rst_gpio", {31'b0, gpio0}, 32'd0);

        resetb0 = 1'b1;
        @(negedge clock);
        check("nb0_gpio", {31'b0, gpio0}, 32'd1);
        check("nb0_pads", {24'b0, mprj_io0[7:0]}, 32'd0);

        resetb = 1'b1;
        run_sequence("run1", NUM_BYTES);

        resetb = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
        run_sequence("pre", 4);
        repeat (10) @(negedge clock);
        resetb = 1'b0;
        @(negedge clock);
        check("midrst_csb", {31'b0, flash_csb}, 32'd1);
        check("midrst_pads", {24'b0, mprj_io[7:0]}, 32'd0);
        check("midrst_clk", {31'b0, flash_clk}, 32'd0);
        resetb = 1'b1;
        run_sequence("replay", NUM_BYTES);

        vccd1 = 1'b0;
        @(negedge clock);
        check("vccd1_csb", {31'b0, flash_csb}, 32'd1);
        check("vccd1_gpio", {31'b0, gpio}, 32'd0);
        repeat (5) @(negedge clock);
        check("vccd1_hold_csb", {31'b0, flash_csb}, 32'd1);
        check("vccd1_hold_pads", {24'b0, mprj_io[7:0]}, 32'd0);
        vccd1 = 1'b1;
        run_sequence("vccd1", NUM_BYTES);

        check("hiz_upper", {31'b0, hiz_bad}, 32'd0);
        check("nb0_csb_idle", {31'b0, csb0_bad}, 32'd0);
        check("io0_data_zero", {31'b0, io0_bad}, 32'd0);
        check("nb0_final_pads", {24'b0, mprj_io0[7:0]}, 32'd0);
        check("nb0_final_gpio", {31'b0, gpio0}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
